apb_slave_fifo: RTL and testbench

- Synchronous 8-entry FIFO buffering APB write transfers (address + write data) between the round-robin arbiter and an APB slave port.
- The upstream side pushes {addr, wdata} pairs; the slave-side sequencer pops them in order.
- Provides a push acknowledge and full/empty status flags for arbiter back-pressure.

---
 rtl/apb_ic_pkg.sv | 13 +
 rtl/fifo_mem.sv | 40 ++++
 rtl/apb_slave_fifo.sv | 103 ++++++++++
 tb/tb_apb_slave_fifo.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/apb_ic_pkg.sv
// Shared types and widths for the APB interconnect: arbiter, FIFO and slave sequencer.
package apb_ic_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    // One buffered APB write transfer; address sits in the upper bits.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } fifo_entry_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the APB write FIFO: synchronous write port and a registered
// read port whose output holds between reads and clears on reset.
module fifo_mem
    import apb_ic_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEn_i,
    input  logic [PTR_W-1:0]  wrPtr_i,
    input  fifo_entry_t       wrData_i,
    input  logic              rdEn_i,
    input  logic [PTR_W-1:0]  rdPtr_i,
    output fifo_entry_t       rdData_o
);

    fifo_entry_t mem_q [DEPTH];
    fifo_entry_t rdData_q;

    // Entry storage; contents are don't-care after reset so no reset branch here.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem_q[wrPtr_i] <= wrData_i;
        end
    end

    // Read register captures the entry at the read pointer and otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdData_q <= '0;
        end else if (rdEn_i) begin
            rdData_q <= mem_q[rdPtr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/apb_slave_fifo.sv
// 8-entry FIFO buffering APB write transfers between the round-robin arbiter and
// the APB slave sequencer. Pointer, occupancy count and registered flags live here.
module apb_slave_fifo #(
    parameter int DATA_W = apb_ic_pkg::DATA_W,
    parameter int ADDR_W = apb_ic_pkg::ADDR_W,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_in,
    input  logic              write,
    input  logic [DATA_W-1:0] push_wdata_in,
    input  logic [ADDR_W-1:0] push_addr_in,
    input  logic              pop_in,
    output logic [DATA_W-1:0] pop_wdata_out,
    output logic [ADDR_W-1:0] pop_addr_out,
    output logic              data_in_ack,
    output logic              full_o,
    output logic              empty_o
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ack_q;
    logic             pushOk;
    logic             popOk;

    apb_ic_pkg::fifo_entry_t wrEntry;
    apb_ic_pkg::fifo_entry_t rdEntry;

    // Both requests are qualified against the flags as they stood before the edge.
    assign pushOk = push_in & write & ~full_q;
    assign popOk  = pop_in & ~empty_q;

    assign wrEntry.addr  = push_addr_in;
    assign wrEntry.wdata = push_wdata_in;

    fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk      (clk),
        .reset    (reset),
        .wrEn_i   (pushOk),
        .wrPtr_i  (wrPtr_q),
        .wrData_i (wrEntry),
        .rdEn_i   (popOk),
        .rdPtr_i  (rdPtr_q),
        .rdData_o (rdEntry)
    );

    // Next pointers, count and flags; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popOk) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (pushOk && !popOk) begin
            count_d = count_q + CNT_W'(1);
        end else if (popOk && !pushOk) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // State register; reset wins over any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ack_q   <= pushOk;
        end
    end

    assign pop_wdata_out = rdEntry.wdata;
    assign pop_addr_out  = rdEntry.addr;
    assign data_in_ack   = ack_q;
    assign full_o        = full_q;
    assign empty_o       = empty_q;

endmodule

// File: tb/tb_apb_slave_fifo.sv
// Directed self-checking bench for apb_slave_fifo with hand-computed expectations.
module tb_apb_slave_fifo;

    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        push_in;
    logic        write;
    logic [31:0] push_wdata_in;
    logic [31:0] push_addr_in;
    logic        pop_in;
    logic [31:0] pop_wdata_out;
    logic [31:0] pop_addr_out;
    logic        data_in_ack;
    logic        full_o;
    logic        empty_o;

    int testCount;
    int failCount;
    int ackPulses;

    apb_slave_fifo dut (
        .clk           (clk),
        .reset         (reset),
        .push_in       (push_in),
        .write         (write),
        .push_wdata_in (push_wdata_in),
        .push_addr_in  (push_addr_in),
        .pop_in        (pop_in),
        .pop_wdata_out (pop_wdata_out),
        .pop_addr_out  (pop_addr_out),
        .data_in_ack   (data_in_ack),
        .full_o        (full_o),
        .empty_o       (empty_o)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the rising edge consume them, then sample on the falling edge.
    task automatic applyStimulus(input logic rstV, input logic pushV, input logic writeV,
                                 input logic [31:0] wdataV, input logic [31:0] addrV,
                                 input logic popV);
        reset         = rstV;
        push_in       = pushV;
        write         = writeV;
        push_wdata_in = wdataV;
        push_addr_in  = addrV;
        pop_in        = popV;
        @(posedge clk);
        @(negedge clk);
        if (data_in_ack === 1'b1) ackPulses++;
        checkOutput("flags_exclusive", 32'(full_o & empty_o), 32'd0);
        checkOutput("count_bound", 32'(dut.count_q <= 4'(DEPTH)), 32'd1);
    endtask

    task automatic checkPop(input string tag, input logic [31:0] expWdata, input logic [31:0] expAddr);
        checkOutput({tag, "_wdata"}, pop_wdata_out, expWdata);
        checkOutput({tag, "_addr"}, pop_addr_out, expAddr);
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        ackPulses = 0;
        reset = 1'b1; push_in = 1'b0; write = 1'b0; pop_in = 1'b0;
        push_wdata_in = '0; push_addr_in = '0;

        // Reset and idle
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        checkOutput("rst_empty", 32'(empty_o), 32'd1);
        checkOutput("rst_full", 32'(full_o), 32'd0);
        checkOutput("rst_ack", 32'(data_in_ack), 32'd0);
        checkPop("rst_pop", 0, 0);

        // Fill with 8 entries
        ackPulses = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'(i * 10), 32'(i * 4), 1'b0);
            checkOutput($sformatf("fill_ack%0d", i), 32'(data_in_ack), 32'd1);
            checkOutput($sformatf("fill_empty%0d", i), 32'(empty_o), 32'd0);
            checkOutput($sformatf("fill_full%0d", i), 32'(full_o), (i == 7) ? 32'd1 : 32'd0);
        end
        checkOutput("fill_ack_pulses", 32'(ackPulses), 32'd8);

        // Push while full is dropped
        applyStimulus(1'b0, 1'b1, 1'b1, 999, 999, 1'b0);
        checkOutput("full_push_ack", 32'(data_in_ack), 32'd0);
        checkOutput("full_push_full", 32'(full_o), 32'd1);

        // Drain 8 in order, then a pop on empty holds the outputs
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
            checkPop($sformatf("drain%0d", i), 32'(i * 10), 32'(i * 4));
            checkOutput($sformatf("drain_full%0d", i), 32'(full_o), 32'd0);
        end
        checkOutput("drain_empty", 32'(empty_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        checkPop("empty_pop_hold", 70, 28);
        checkOutput("empty_pop_empty", 32'(empty_o), 32'd1);

        // Wrap-around: push 5, pop 3, then 6 simultaneous push/pop
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 32'(100 + i), 32'(256 + i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
            checkPop($sformatf("wrap_pop%0d", i), 32'(100 + i), 32'(256 + i));
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'(105 + i), 32'(261 + i), 1'b1);
            checkPop($sformatf("sim_pop%0d", i), 32'(103 + i), 32'(259 + i));
            checkOutput($sformatf("sim_ack%0d", i), 32'(data_in_ack), 32'd1);
            checkOutput($sformatf("sim_empty%0d", i), 32'(empty_o), 32'd0);
            checkOutput($sformatf("sim_full%0d", i), 32'(full_o), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        checkPop("wrap_tail0", 109, 265);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        checkPop("wrap_tail1", 110, 266);
        checkOutput("wrap_empty", 32'(empty_o), 32'd1);

        // Push+pop on empty stores only, no write-through
        applyStimulus(1'b0, 1'b1, 1'b1, 200, 400, 1'b1);
        checkPop("pp_empty_hold", 110, 266);
        checkOutput("pp_empty_ack", 32'(data_in_ack), 32'd1);
        checkOutput("pp_empty_empty", 32'(empty_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        checkPop("pp_empty_later", 200, 400);
        checkOutput("pp_empty_drained", 32'(empty_o), 32'd1);

        // Push+pop on full pops only
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 32'(300 + i), 32'(600 + i), 1'b0);
        checkOutput("pp_full_pre", 32'(full_o), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 999, 999, 1'b1);
        checkPop("pp_full_pop", 300, 600);
        checkOutput("pp_full_ack", 32'(data_in_ack), 32'd0);
        checkOutput("pp_full_full", 32'(full_o), 32'd0);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
            checkPop($sformatf("pp_full_drain%0d", i), 32'(300 + i), 32'(600 + i));
        end
        checkOutput("pp_full_empty", 32'(empty_o), 32'd1);

        // Push with write=0 is ignored
        applyStimulus(1'b0, 1'b1, 1'b0, 555, 555, 1'b0);
        checkOutput("rd_push_ack", 32'(data_in_ack), 32'd0);
        checkOutput("rd_push_empty", 32'(empty_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        checkPop("rd_push_hold", 307, 607);
        applyStimulus(1'b0, 1'b1, 1'b1, 500, 1000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        checkPop("rd_push_next", 500, 1000);

        // Reset mid-operation discards stored entries, overriding a concurrent push
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 32'(700 + i), 32'(800 + i), 1'b0);
        checkOutput("midrst_pre_empty", 32'(empty_o), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 900, 900, 1'b1);
        checkOutput("midrst_empty", 32'(empty_o), 32'd1);
        checkOutput("midrst_full", 32'(full_o), 32'd0);
        checkOutput("midrst_ack", 32'(data_in_ack), 32'd0);
        checkPop("midrst_out", 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        checkPop("midrst_pop", 0, 0);
        checkOutput("midrst_pop_empty", 32'(empty_o), 32'd1);

        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
